// File: rtl/mult_div_unit.sv
// ============================================================================
//  Module   : mult_div_unit
//  Purpose  : Iterative multiply/divide unit owning the architectural HI/LO
//             registers. MULT/MULTU use radix-2 shift-add, DIV/DIVU use
//             restoring division. Each needs WIDTH+1 cycles from the start
//             edge to the done pulse. MTHI/MTLO write HI/LO in one edge.
//  Ports    : clock  - rising-edge clock
//             reset  - synchronous active-high reset
//             start  - one-cycle request strobe
//             op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO
//             a, b   - rs / rt operands
//             busy   - MULT/DIV in progress
//             done   - one-cycle pulse when new hi/lo are valid
//             hi, lo - HI / LO registers
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_FIN  = 2'd2;

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;

  localparam logic [CW-1:0]    c_CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    c_CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] c_ZERO     = '0;

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // mult: {partial, multiplier}; div: {rem, quo}
  logic [WIDTH-1:0]   r_b;       // multiplicand magnitude or divisor magnitude
  logic               r_is_div;
  logic               r_neg_q;   // negate product / quotient
  logic               r_neg_r;   // negate remainder (dividend was negative)
  logic               r_divz;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  // Operand magnitudes: op[0]=0 selects the signed flavour of MULT/DIV.
  logic               w_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;

  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (w_signed && b[WIDTH-1]) ? -b : b;

  // Shift-add step: conditionally add multiplicand into the upper half,
  // then shift the whole accumulator right, carry included.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : c_ZERO)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: the shifted remainder needs WIDTH+1 bits because it can
  // reach twice the divisor before the trial subtraction.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

  // Final sign fix-up applied at FIN.
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fin = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_divz) begin
        w_hi_fin = c_ZERO;
        w_lo_fin = c_ZERO;
      end else begin
        w_lo_fin = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_hi_fin = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            case (op)
              c_OP_MULT, c_OP_MULTU, c_OP_DIV, c_OP_DIVU: begin
                r_is_div <= op[1];
                r_acc    <= op[1] ? {c_ZERO, w_abs_a} : {c_ZERO, w_abs_b};
                r_b      <= op[1] ? w_abs_b : w_abs_a;
                r_neg_q  <= w_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg_r  <= w_signed && a[WIDTH-1];
                r_divz   <= (b == c_ZERO);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_state  <= c_RUN;
              end
              c_OP_MTHI: r_hi <= a;
              c_OP_MTLO: r_lo <= a;
              default: ;
            endcase
          end
        end
        c_RUN: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= c_FIN;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_FIN: begin
          r_hi    <= w_hi_fin;
          r_lo    <= w_lo_fin;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
//  Module   : tb_mult_div_unit
//  Purpose  : Directed self-checking bench for mult_div_unit (WIDTH=32).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_err;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Issues an op at the current time (1 time unit after an edge), then
  // counts edges until done. lat = edge index of done (-1 if never seen),
  // busy_bad = cycles before done with busy low, hl_bad = cycles before done
  // where hi/lo moved.
  task automatic run_op(input logic [2:0] i_op, input logic [31:0] i_a,
                        input logic [31:0] i_b, output int lat,
                        output int busy_bad, output int hl_bad);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    lat = -1;
    busy_bad = 0;
    hl_bad = 0;
    start = 1'b1; op = i_op; a = i_a; b = i_b;
    @(posedge clock); #1;
    start = 1'b0;
    if (busy !== 1'b1) busy_bad++;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (hi !== hi0 || lo !== lo0) hl_bad++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult_signed();
    int lat, bb, hb;
    run_op(3'd0, 32'hFFFFFFFD, 32'd5, lat, bb, hb);
    n_vec++;
    if (lat !== 33) begin n_err++; $display("FAIL mult_latency: got %0d want 33", lat); end
    n_vec++;
    if (bb !== 0) begin n_err++; $display("FAIL mult_busy: %0d cycles low, want 0", bb); end
    n_vec++;
    if (hb !== 0) begin n_err++; $display("FAIL mult_hilo_stable: %0d changes, want 0", hb); end
    n_vec++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      n_err++; $display("FAIL mult_result: got %h_%h want ffffffff_fffffff1", hi, lo);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL mult_busy_at_done: got %b want 0", busy); end
    @(posedge clock); #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    int lat, bb, hb;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bb, hb);
    n_vec++;
    if (lat !== 33 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      n_err++; $display("FAIL multu_max: lat=%0d got %h_%h want 33 fffffffe_00000001", lat, hi, lo);
    end
    // issued during the done cycle
    run_op(3'd3, 32'd100, 32'd7, lat, bb, hb);
    n_vec++;
    if (lat !== 33 || bb !== 0) begin
      n_err++; $display("FAIL b2b_divu_timing: lat=%0d busy_low=%0d want 33 0", lat, bb);
    end
    n_vec++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_err++; $display("FAIL divu_100_7: got hi=%h lo=%h want 00000002 0000000e", hi, lo);
    end
  endtask

  task automatic test_div_signed();
    int lat, bb, hb;
    @(posedge clock); #1;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, lat, bb, hb);
    n_vec++;
    if (lat !== 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL div_neg7_2: lat=%0d got hi=%h lo=%h want 33 ffffffff fffffffd", lat, hi, lo);
    end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, lat, bb, hb);
    n_vec++;
    if (lat !== 33 || hi !== 32'h0 || lo !== 32'h80000000) begin
      n_err++; $display("FAIL div_overflow: lat=%0d got hi=%h lo=%h want 33 00000000 80000000", lat, hi, lo);
    end
    run_op(3'd2, 32'd7, 32'hFFFFFFFE, lat, bb, hb);
    n_vec++;
    if (hi !== 32'd1 || lo !== 32'hFFFFFFFD) begin
      n_err++; $display("FAIL div_7_neg2: got hi=%h lo=%h want 00000001 fffffffd", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    int lat, bb, hb;
    run_op(3'd3, 32'd1234, 32'd0, lat, bb, hb);
    n_vec++;
    if (lat !== 33 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL divu_by_zero: lat=%0d done=%b got hi=%h lo=%h want 33 1 0 0", lat, done, hi, lo);
    end
  endtask

  task automatic test_mthi_and_ignore();
    int lat;
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF; b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0;
    n_vec++;
    if (hi !== 32'hDEADBEEF || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL mthi: got hi=%h busy=%b done=%b want deadbeef 0 0", hi, busy, done);
    end
    @(posedge clock); #1;
    // MULT 2*3 with an MTLO strobe during RUN that must be dropped
    lat = -1;
    start = 1'b1; op = 3'd0; a = 32'd2; b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin
        start = 1'b1; op = 3'd5; a = 32'h55;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    n_vec++;
    if (lat !== 33 || hi !== 32'd0 || lo !== 32'd6) begin
      n_err++; $display("FAIL mtlo_ignored: lat=%0d got hi=%h lo=%h want 33 0 6", lat, hi, lo);
    end
  endtask

  task automatic test_reset_midop();
    int dcount;
    @(posedge clock); #1;
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL reset_midop: got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (done === 1'b1) dcount++;
    end
    n_vec++;
    if (dcount !== 0) begin
      n_err++; $display("FAIL no_done_after_reset: got %0d pulses want 0", dcount);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_mthi_and_ignore();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
